spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
Shares one byte-level SPI_Master and a single sensor chip-select between NUM_REQ independent requesters, e.g. a temperature poller, an accel/gyro poller and a config writer.
Each request is a register transaction: either a single-byte write, or a burst read of 1..MAX_LEN bytes.
The block arbitrates round-robin, frames chip-select with setup, hold and gap timing, sequences the address, data and dummy bytes, and routes read bytes back tagged with the requester ID.
It sits between the sensor-specific pollers and SPI_Master.

Parameters:
NUM_REQ, 3, number of requesters (2..4)
MAX_LEN, 8, maximum burst read length in bytes
LEN_W, 3, width of length field; encodes MAX_LEN-1 (0 means 1 byte)
CS_SETUP_CLKS, 4, i_Clk cycles from CS low to the first TX_DV
CS_HOLD_CLKS, 4, i_Clk cycles from the last RX_DV to CS high
CS_GAP_CLKS, 8, minimum i_Clk cycles CS stays high between transactions

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous, active-low reset
i_req  in  NUM_REQ  per-requester request-pending level
i_req_rd  in  NUM_REQ  1 = burst read, 0 = single write
i_req_addr  in  NUM_REQ*7  register address, requester k at bits [7k+6:7k]
i_req_len  in  NUM_REQ*LEN_W  read length minus 1 (ignored for writes)
i_req_wdata  in  NUM_REQ*8  write data byte
o_grant  out  NUM_REQ  one-hot, 1-cycle pulse when a request is accepted
o_rd_dv  out  1  1-cycle pulse: o_rd_byte valid
o_rd_byte  out  8  read data byte
o_rd_id  out  2  requester index that owns o_rd_byte
o_done  out  NUM_REQ  one-hot, 1-cycle pulse when the transaction completes (CS already high)
o_busy  out  1  high from grant until the gap ends
o_TX_Byte  out  8  to SPI_Master i_TX_Byte
o_TX_DV  out  1  to SPI_Master i_TX_DV
i_TX_Ready  in  1  from SPI_Master o_TX_Ready
i_RX_DV  in  1  from SPI_Master o_RX_DV
i_RX_Byte  in  8  from SPI_Master o_RX_Byte
o_cs_n  out  1  active-low sensor chip-select

Behaviour:
- Reset: immediately and asynchronously forces the following.
  - Outputs: o_cs_n=1; o_TX_DV, o_rd_dv, o_grant, o_done, o_busy=0; o_TX_Byte, o_rd_byte, o_rd_id=0.
  - Internal: round-robin pointer = NUM_REQ-1, so requester 0 has first priority; state=IDLE.
  - Reset mid-transaction abandons the transaction. No o_done is issued.
- States: IDLE -> CS_SETUP -> SEND -> DRAIN -> CS_HOLD -> GAP -> IDLE.
- IDLE:
  - If any i_req bit is set, grant the first set bit searching from pointer+1 with wrap.
  - Pulse o_grant[k] and latch rd, addr, len and wdata for requester k.
  - Set pointer=k, drive o_cs_n=0, o_busy=1, go to CS_SETUP.
  - Arbitration takes 1 cycle. The requester must deassert i_req[k] on its grant; a level still high after done is a new request.
  - A request dropped before grant is never served.
- CS_SETUP: count CS_SETUP_CLKS, then go to SEND.
- Byte counts: total = 1+len+1 for reads, 2 for writes.
- SEND:
  - Each cycle with i_TX_Ready=1 and bytes-to-send > 0: pulse o_TX_DV for 1 cycle with o_TX_Byte.
  - Byte 0 = {rd,addr}; read sets bit7=1.
  - Following bytes = wdata (write) or 8'h00 dummy (read).
  - Never assert o_TX_DV twice without i_TX_Ready between.
  - When bytes-to-send reaches 0, go to DRAIN.
- RX counting applies in SEND and DRAIN:
  - Count every i_RX_DV.
  - The first RX byte (address phase) is discarded, as are all write-phase RX bytes.
  - For reads, RX bytes 1..len+1 each pulse o_rd_dv with o_rd_byte=i_RX_Byte and o_rd_id=k in the cycle after i_RX_DV.
  - When RX count reaches total, go to CS_HOLD.
- CS_HOLD: count CS_HOLD_CLKS, then set o_cs_n=1, pulse o_done[k], go to GAP.
- GAP: count CS_GAP_CLKS with CS high, then clear o_busy and go to IDLE. No grant is issued during GAP.
- Simultaneous requests: strict round-robin. A requester holding i_req continuously waits at most NUM_REQ-1 transactions.
- i_RX_DV outside SEND/DRAIN is ignored.
- len=MAX_LEN-1 is legal: MAX_LEN data bytes.
- Counters are sized for MAX_LEN+1 with no wrap.

Decomposition:
- Package spi_arb_pkg holds:
  - the state encoding;
  - the READ_FLAG 8'h80 constant;
  - the DUMMY_BYTE 8'h00 constant;
  - a function building the address byte.
- Natural sub-module: rr_arbiter (NUM_REQ request in, pointer in, one-hot grant out, purely combinational). The FSM, counters and routing stay in the top module.

Test Plan:
- Single read: req0 rd, addr 0x41, len=1, MISO model returns 0x0A,0xBC.
  -> TX bytes 0xC1,0x00,0x00.
  -> o_rd_dv twice with 0x0A then 0xBC, id=0.
  -> o_done[0] after CS high.
  -> CS low-to-first-DV >= 4 clks.
- Single write: req2 write, addr 0x6B, wdata 0x00.
  -> TX bytes 0x6B,0x00; no o_rd_dv; o_done[2].
  -> CS high >= 8 clks before any next CS low.
- Contention: all three req high from reset, held until granted, then re-raised.
  -> grants in order 0,1,2,0,1,2.
  -> never two CS-low windows without a gap of >= 8 clks between them.
- Max burst: len=7 read.
  -> exactly 8 o_rd_dv pulses, 9 TX_DV pulses, RX byte 0 never forwarded.
- Slow master: i_TX_Ready held low for 20 clks between bytes.
  -> o_TX_DV waits, no lost or duplicated bytes, identical data.
- Reset mid-burst after 3 bytes.
  -> o_cs_n=1 and all pulses low within the reset.
  -> no o_done; the next request after reset is served correctly starting from requester 0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SEND,
        ST_DRAIN,
        ST_CS_HOLD,
        ST_GAP
    } state_e;

    localparam logic [7:0] READ_FLAG  = 8'h80;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    // First byte on the wire: bit7 selects read, bits 6:0 are the register address.
    function automatic logic [7:0] addr_byte(input logic rd, input logic [6:0] addr);
        return rd ? (READ_FLAG | {1'b0, addr}) : {1'b0, addr};
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr_i, with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_REQ-1:0] grant_c_o,
    output logic [1:0]         idx_c_o
);

    logic       found;
    logic [1:0] j;

    always_comb begin
        grant_c_o = '0;
        idx_c_o   = '0;
        found     = 1'b0;
        j         = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            j = 2'((32'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[j]) begin
                grant_c_o[j] = 1'b1;
                idx_c_o      = j;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one byte-level SPI master and chip-select between NUM_REQ register-transaction requesters.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 3,
    parameter int unsigned MAX_LEN       = 8,
    parameter int unsigned LEN_W         = 3,
    parameter int unsigned CS_SETUP_CLKS = 4,
    parameter int unsigned CS_HOLD_CLKS  = 4,
    parameter int unsigned CS_GAP_CLKS   = 8
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ-1:0]       i_req_rd,
    input  logic [NUM_REQ*7-1:0]     i_req_addr,
    input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
    input  logic [NUM_REQ*8-1:0]     i_req_wdata,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_rd_dv,
    output logic [7:0]               o_rd_byte,
    output logic [1:0]               o_rd_id,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_busy,
    output logic [7:0]               o_TX_Byte,
    output logic                     o_TX_DV,
    input  logic                     i_TX_Ready,
    input  logic                     i_RX_DV,
    input  logic [7:0]               i_RX_Byte,
    output logic                     o_cs_n
);

    localparam int unsigned TOT_W   = $clog2(MAX_LEN + 2);
    localparam int unsigned TMR_MAX = (CS_GAP_CLKS > CS_SETUP_CLKS)
                                    ? ((CS_GAP_CLKS > CS_HOLD_CLKS) ? CS_GAP_CLKS : CS_HOLD_CLKS)
                                    : ((CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_e             state_q;
    logic [1:0]         ptr_q;
    logic [1:0]         id_q;
    logic               rd_q;
    logic [6:0]         addr_q;
    logic [7:0]         wdata_q;
    logic [TOT_W-1:0]   total_q;
    logic [TOT_W-1:0]   tx_cnt_q;
    logic [TOT_W-1:0]   rx_cnt_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               rd_dv_q;
    logic [7:0]         rd_byte_q;
    logic [1:0]         rd_id_q;
    logic               busy_q;
    logic [7:0]         tx_byte_q;
    logic               tx_dv_q;
    logic               cs_n_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [1:0]         arb_idx;
    logic               sel_rd;
    logic [6:0]         sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic [7:0]         sel_wdata;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req_i     (i_req),
        .ptr_i     (ptr_q),
        .grant_c_o (arb_grant),
        .idx_c_o   (arb_idx)
    );

    // Fields of the requester that would win this cycle.
    always_comb begin
        sel_rd    = i_req_rd[arb_idx];
        sel_addr  = i_req_addr[arb_idx*7 +: 7];
        sel_len   = i_req_len[arb_idx*LEN_W +: LEN_W];
        sel_wdata = i_req_wdata[arb_idx*8 +: 8];
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'(NUM_REQ - 1);
            id_q      <= '0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            total_q   <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            tmr_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            rd_dv_q   <= 1'b0;
            rd_byte_q <= '0;
            rd_id_q   <= '0;
            busy_q    <= 1'b0;
            tx_byte_q <= '0;
            tx_dv_q   <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            rd_dv_q <= 1'b0;
            tx_dv_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|i_req) begin
                        grant_q  <= arb_grant;
                        ptr_q    <= arb_idx;
                        id_q     <= arb_idx;
                        rd_q     <= sel_rd;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        total_q  <= sel_rd ? (TOT_W'(sel_len) + TOT_W'(2)) : TOT_W'(2);
                        tx_cnt_q <= '0;
                        rx_cnt_q <= '0;
                        tmr_q    <= '0;
                        cs_n_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_CS_SETUP;
                    end
                end
                ST_CS_SETUP: begin
                    if (tmr_q == TMR_W'(CS_SETUP_CLKS - 1)) begin
                        tmr_q   <= '0;
                        state_q <= ST_SEND;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_SEND, ST_DRAIN: begin
                    // tx_dv_q guard keeps one strobe per ready window.
                    if (state_q == ST_SEND && i_TX_Ready && !tx_dv_q && tx_cnt_q != total_q) begin
                        tx_dv_q   <= 1'b1;
                        tx_byte_q <= (tx_cnt_q == '0) ? addr_byte(rd_q, addr_q)
                                   : (rd_q ? DUMMY_BYTE : wdata_q);
                        tx_cnt_q  <= tx_cnt_q + TOT_W'(1);
                        if (tx_cnt_q + TOT_W'(1) == total_q) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                    if (i_RX_DV) begin
                        rx_cnt_q <= rx_cnt_q + TOT_W'(1);
                        if (rd_q && rx_cnt_q != '0) begin
                            rd_dv_q   <= 1'b1;
                            rd_byte_q <= i_RX_Byte;
                            rd_id_q   <= id_q;
                        end
                        if (rx_cnt_q + TOT_W'(1) == total_q) begin
                            tmr_q   <= '0;
                            state_q <= ST_CS_HOLD;
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (tmr_q == TMR_W'(CS_HOLD_CLKS - 1)) begin
                        tmr_q        <= '0;
                        cs_n_q       <= 1'b1;
                        done_q[id_q] <= 1'b1;
                        state_q      <= ST_GAP;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (tmr_q == TMR_W'(CS_GAP_CLKS - 1)) begin
                        tmr_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_grant   = grant_q;
    assign o_done    = done_q;
    assign o_rd_dv   = rd_dv_q;
    assign o_rd_byte = rd_byte_q;
    assign o_rd_id   = rd_id_q;
    assign o_busy    = busy_q;
    assign o_TX_Byte = tx_byte_q;
    assign o_TX_DV   = tx_dv_q;
    assign o_cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter with a byte-level SPI master model.
module tb_spi_txn_arbiter;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned LEN_W   = 3;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       i_req = '0;
    logic [NUM_REQ-1:0]       i_req_rd = '0;
    logic [NUM_REQ*7-1:0]     i_req_addr = '0;
    logic [NUM_REQ*LEN_W-1:0] i_req_len = '0;
    logic [NUM_REQ*8-1:0]     i_req_wdata = '0;
    logic [NUM_REQ-1:0]       o_grant;
    logic                     o_rd_dv;
    logic [7:0]               o_rd_byte;
    logic [1:0]               o_rd_id;
    logic [NUM_REQ-1:0]       o_done;
    logic                     o_busy;
    logic [7:0]               o_TX_Byte;
    logic                     o_TX_DV;
    logic                     i_TX_Ready = 1'b1;
    logic                     i_RX_DV = 1'b0;
    logic [7:0]               i_RX_Byte = '0;
    logic                     o_cs_n;

    always #5 clk = ~clk;

    spi_txn_arbiter #(
        .NUM_REQ(3), .MAX_LEN(8), .LEN_W(3),
        .CS_SETUP_CLKS(4), .CS_HOLD_CLKS(4), .CS_GAP_CLKS(8)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n),
        .i_req(i_req), .i_req_rd(i_req_rd), .i_req_addr(i_req_addr),
        .i_req_len(i_req_len), .i_req_wdata(i_req_wdata),
        .o_grant(o_grant), .o_rd_dv(o_rd_dv), .o_rd_byte(o_rd_byte), .o_rd_id(o_rd_id),
        .o_done(o_done), .o_busy(o_busy),
        .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV), .i_TX_Ready(i_TX_Ready),
        .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte), .o_cs_n(o_cs_n)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_tx[$];
    logic [9:0] exp_rd[$];
    int         exp_grant[$];
    int         exp_done[$];
    logic [7:0] miso_q[$];
    int         lat = 3;
    int         tx_seen = 0;
    int         rd_seen = 0;
    int         reraise[NUM_REQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int min);
        checks++;
        if (act < min) begin
            errors++;
            $display("FAIL %s: got %0d required >= %0d at %0t", name, act, min, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d with nothing expected at %0t", name, act, $time);
    endtask

    // SPI master model: drops ready on TX_DV, returns one MISO byte lat clocks later.
    logic mm_active = 1'b0;
    int   mm_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            i_TX_Ready = 1'b1;
            i_RX_DV    = 1'b0;
            mm_active  = 1'b0;
            mm_cnt     = 0;
        end else begin
            if (o_TX_DV) chk("tx_dv_while_master_busy", 32'(mm_active), 0);
            i_RX_DV = 1'b0;
            if (mm_active) begin
                mm_cnt--;
                if (mm_cnt <= 0) begin
                    i_RX_DV = 1'b1;
                    if (miso_q.size() > 0) i_RX_Byte = miso_q.pop_front();
                    else                   i_RX_Byte = 8'hFF;
                    i_TX_Ready = 1'b1;
                    mm_active  = 1'b0;
                end
            end
            if (o_TX_DV) begin
                mm_active  = 1'b1;
                mm_cnt     = lat;
                i_TX_Ready = 1'b0;
            end
        end
    end

    // Scoreboard monitor plus chip-select timing checks.
    int   hi_run = 0;
    int   lo_run = 0;
    bit   seen_low = 1'b0;
    bit   dv_pending = 1'b0;
    logic cs_prev = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_low   = 1'b0;
            dv_pending = 1'b0;
            cs_prev    = 1'b1;
            hi_run     = 0;
        end else begin
            if (o_TX_DV) begin
                tx_seen++;
                if (exp_tx.size() == 0) fail_now("tx_unexpected", 32'(o_TX_Byte));
                else chk("tx_byte", 32'(o_TX_Byte), 32'(exp_tx.pop_front()));
            end
            if (o_rd_dv) begin
                rd_seen++;
                if (exp_rd.size() == 0) fail_now("rd_unexpected", 32'({o_rd_id, o_rd_byte}));
                else chk("rd_id_byte", 32'({o_rd_id, o_rd_byte}), 32'(exp_rd.pop_front()));
            end
            if (|o_grant) begin
                if (exp_grant.size() == 0) fail_now("grant_unexpected", 32'(o_grant));
                else chk("grant", 32'(o_grant), 32'(1) << exp_grant.pop_front());
            end
            if (|o_done) begin
                if (exp_done.size() == 0) fail_now("done_unexpected", 32'(o_done));
                else chk("done", 32'(o_done), 32'(1) << exp_done.pop_front());
                chk("done_cs_high", 32'(o_cs_n), 1);
            end
            if (!o_cs_n) begin
                if (cs_prev) begin
                    if (seen_low) chk_ge("cs_gap", hi_run, 8);
                    seen_low   = 1'b1;
                    lo_run     = 0;
                    dv_pending = 1'b1;
                end
                if (o_TX_DV && dv_pending) begin
                    chk_ge("cs_setup", lo_run, 4);
                    dv_pending = 1'b0;
                end
                lo_run++;
                hi_run = 0;
            end else begin
                hi_run++;
            end
            cs_prev = o_cs_n;
        end
    end

    task automatic set_req(input int k, input logic rd, input logic [6:0] addr,
                           input int len, input logic [7:0] wdata);
        i_req_rd[k]                 = rd;
        i_req_addr[k*7 +: 7]        = addr;
        i_req_len[k*LEN_W +: LEN_W] = LEN_W'(len);
        i_req_wdata[k*8 +: 8]       = wdata;
    endtask

    task automatic expect_txn(input int k, input logic rd, input logic [7:0] hdr,
                              input int len, input logic [7:0] wdata);
        exp_grant.push_back(k);
        exp_tx.push_back(hdr);
        miso_q.push_back(8'hEE);
        if (rd) begin
            for (int i = 0; i <= len; i++) exp_tx.push_back(8'h00);
        end else begin
            exp_tx.push_back(wdata);
            miso_q.push_back(8'h33);
        end
        exp_done.push_back(k);
    endtask

    task automatic rdata(input int k, input logic [7:0] b);
        miso_q.push_back(b);
        exp_rd.push_back({2'(k), b});
    endtask

    // Requester behaviour: drop on grant, optionally re-raise on done; bounded wait.
    task automatic run(input int budget, input int stop_tx);
        int n = 0;
        forever begin
            @(negedge clk);
            n++;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (o_grant[k]) i_req[k] = 1'b0;
                if (o_done[k] && reraise[k] > 0) begin
                    i_req[k] = 1'b1;
                    reraise[k]--;
                end
            end
            if (stop_tx > 0 && tx_seen >= stop_tx) return;
            if (stop_tx == 0 && i_req == '0 && !o_busy) return;
            if (n >= budget) begin
                fail_now("timeout", n);
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int t0;
        int r0;
        for (int k = 0; k < NUM_REQ; k++) reraise[k] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(o_cs_n), 1);
        chk("rst_tx_dv", 32'(o_TX_DV), 0);
        chk("rst_rd_dv", 32'(o_rd_dv), 0);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_tx_byte", 32'(o_TX_Byte), 0);
        chk("rst_rd_byte", 32'(o_rd_byte), 0);
        chk("rst_rd_id", 32'(o_rd_id), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single read: req0, addr 0x41, len=1.
        set_req(0, 1'b1, 7'h41, 1, 8'h00);
        expect_txn(0, 1'b1, 8'hC1, 1, 8'h00);
        rdata(0, 8'h0A);
        rdata(0, 8'hBC);
        i_req[0] = 1'b1;
        run(600, 0);

        // Single write: req2, addr 0x6B, wdata 0x00.
        set_req(2, 1'b0, 7'h6B, 0, 8'h00);
        expect_txn(2, 1'b0, 8'h6B, 0, 8'h00);
        i_req[2] = 1'b1;
        run(600, 0);

        // Contention from reset: expect 0,1,2,0,1,2.
        do_reset();
        set_req(0, 1'b0, 7'h10, 0, 8'hA0);
        set_req(1, 1'b0, 7'h11, 0, 8'hA1);
        set_req(2, 1'b1, 7'h12, 0, 8'h00);
        for (int r = 0; r < 2; r++) begin
            expect_txn(0, 1'b0, 8'h10, 0, 8'hA0);
            expect_txn(1, 1'b0, 8'h11, 0, 8'hA1);
            expect_txn(2, 1'b1, 8'h92, 0, 8'h00);
            rdata(2, 8'h5A);
        end
        for (int k = 0; k < NUM_REQ; k++) reraise[k] = 1;
        i_req = 3'b111;
        run(3000, 0);

        // Max burst: req1 read, len=7.
        set_req(1, 1'b1, 7'h3B, 7, 8'h00);
        expect_txn(1, 1'b1, 8'hBB, 7, 8'h00);
        for (int i = 1; i <= 8; i++) rdata(1, 8'(8'h11 * i));
        t0 = tx_seen;
        r0 = rd_seen;
        i_req[1] = 1'b1;
        run(1000, 0);
        chk("burst_tx_count", 32'(tx_seen - t0), 9);
        chk("burst_rd_count", 32'(rd_seen - r0), 8);

        // Slow master: 20-clock ready-low windows.
        lat = 20;
        set_req(0, 1'b1, 7'h20, 2, 8'h00);
        expect_txn(0, 1'b1, 8'hA0, 2, 8'h00);
        rdata(0, 8'hC1);
        rdata(0, 8'h02);
        rdata(0, 8'h7E);
        t0 = tx_seen;
        i_req[0] = 1'b1;
        run(2000, 0);
        chk("slow_tx_count", 32'(tx_seen - t0), 4);
        lat = 3;

        // Reset after the third TX byte of a burst.
        set_req(1, 1'b1, 7'h30, 7, 8'h00);
        exp_grant.push_back(1);
        exp_tx.push_back(8'hB0);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00);
        miso_q.push_back(8'hEE);
        miso_q.push_back(8'h71);
        miso_q.push_back(8'h72);
        rdata(1, 8'h71);
        void'(exp_rd.pop_back());
        exp_rd.push_back({2'd1, 8'h71});
        i_req[1] = 1'b1;
        run(500, tx_seen + 3);
        chk("mid_cs_low", 32'(o_cs_n), 0);
        rst_n = 1'b0;
        i_req = '0;
        #1;
        chk("abort_cs_n", 32'(o_cs_n), 1);
        chk("abort_tx_dv", 32'(o_TX_DV), 0);
        chk("abort_rd_dv", 32'(o_rd_dv), 0);
        chk("abort_grant", 32'(o_grant), 0);
        chk("abort_done", 32'(o_done), 0);
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_tx_left", 32'(exp_tx.size()), 0);
        chk("abort_rd_left", 32'(exp_rd.size()), 0);
        miso_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // After reset requester 0 wins over requester 1.
        set_req(0, 1'b0, 7'h0F, 0, 8'h5A);
        set_req(1, 1'b0, 7'h7F, 0, 8'hFF);
        expect_txn(0, 1'b0, 8'h0F, 0, 8'h5A);
        expect_txn(1, 1'b0, 8'h7F, 0, 8'hFF);
        i_req = 3'b011;
        run(1500, 0);

        repeat (5) @(negedge clk);
        chk("end_tx_left", 32'(exp_tx.size()), 0);
        chk("end_rd_left", 32'(exp_rd.size()), 0);
        chk("end_grant_left", 32'(exp_grant.size()), 0);
        chk("end_done_left", 32'(exp_done.size()), 0);
        chk("end_cs_n", 32'(o_cs_n), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
